// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RISC-V load/store width
// codes, controller state encoding and byte-enable width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_bram.sv
// Word-organised RAM: synchronous read, per-byte write enables, no reset,
// contents undefined at power-up.
module dmem_bram
  import dmem_pkg::*;
#(
  parameter int unsigned AW = 7
) (
  input  logic            clk,
  input  logic            re,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller in front of a byte-enable RAM: handles RISC-V widths,
// sign/zero extension, alignment faults and a valid/ready response channel.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_ctrl: DATA_W must be 32");
  end

  state_t state;

  logic              accept;
  logic              ld_legal;
  logic              st_legal;
  logic              misaligned;
  logic              fault;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wd;
  logic [BE_W-1:0]   ram_be;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    ld_legal   = 1'b0;
    st_legal   = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: ld_legal = 1'b1;
      F3_H, F3_HU: ld_legal = 1'b1;
      F3_W:        ld_legal = 1'b1;
      default:     ld_legal = 1'b0;
    endcase
    case (req_funct3)
      F3_B, F3_H, F3_W: st_legal = 1'b1;
      default:          st_legal = 1'b0;
    endcase
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = |req_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
    fault = (req_we ? !st_legal : !ld_legal) || misaligned;
  end

  always_comb begin
    lane_be = '0;
    lane_wd = '0;
    case (req_funct3[1:0])
      2'b00: begin
        lane_be = 4'b0001 << req_addr[1:0];
        lane_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_be = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_be = 4'b1111;
        lane_wd = req_wdata;
      end
    endcase
    ram_be = (accept && req_we && !fault) ? lane_be : '0;
    ram_re = accept && !req_we && !fault;
  end

  dmem_bram #(
    .AW (ADDR_W - 2)
  ) u_bram (
    .clk   (clk),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (req_addr[ADDR_W-1:2]),
    .wdata (lane_wd),
    .rdata (ram_rdata)
  );

  // Load extraction uses the offset/width captured at acceptance.
  always_comb begin
    ld_byte = '0;
    case (lo_q)
      2'd0:    ld_byte = ram_rdata[7:0];
      2'd1:    ld_byte = ram_rdata[15:8];
      2'd2:    ld_byte = ram_rdata[23:16];
      default: ld_byte = ram_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (f3_q)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q <= req_funct3;
            lo_q <= req_addr[1:0];
            if (fault || req_we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= fault;
              rsp_rdata <= '0;
            end else begin
              state     <= READ;
              rsp_fault <= 1'b0;
            end
          end
        end
        READ: begin
          rsp_rdata <= ld_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: one task per scenario, each
// comparing against hand-computed values.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int nchk = 0;
  int nerr = 0;

  dmem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault)
  );

  always #5 clk = ~clk;

  // Issues one request and consumes its response; lat counts rising edges
  // from the acceptance edge to the first edge that sees rsp_valid high.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic flt);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      nchk++; nerr++;
      $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    rd  = rsp_rdata;
    flt = rsp_fault;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #3;
    nchk++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL rst_req_ready: got %0b need 0", req_ready); end
    nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_rsp_valid: got %0b need 0", rsp_valid); end
    nchk++; if (rsp_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rsp_rdata: got %h need 0", rsp_rdata); end
    nchk++; if (rsp_fault !== 1'b0) begin nerr++; $display("FAIL rst_rsp_fault: got %0b need 0", rsp_fault); end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    nchk++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready: got %0b need 1", req_ready); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic flt;
    do_req(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, lat, rd, flt);
    nchk++; if (lat !== 1) begin nerr++; $display("FAIL sw_latency: got %0d need 1", lat); end
    nchk++; if (rd !== 32'h0 || flt !== 1'b0) begin nerr++; $display("FAIL sw_rsp: got %h/%0b need 0/0", rd, flt); end
    do_req(1'b0, 3'b010, 9'h010, 32'h0, lat, rd, flt);
    nchk++; if (lat !== 2) begin nerr++; $display("FAIL lw_latency: got %0d need 2", lat); end
    nchk++; if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin nerr++; $display("FAIL lw_data: got %h/%0b need deadbeef/0", rd, flt); end
  endtask

  task automatic test_load_ext();
    int lat; logic [31:0] rd; logic flt;
    do_req(1'b0, 3'b000, 9'h013, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'hFFFFFFDE) begin nerr++; $display("FAIL lb_13: got %h need ffffffde", rd); end
    do_req(1'b0, 3'b100, 9'h013, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h000000DE) begin nerr++; $display("FAIL lbu_13: got %h need 000000de", rd); end
    do_req(1'b0, 3'b001, 9'h010, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'hFFFFBEEF) begin nerr++; $display("FAIL lh_10: got %h need ffffbeef", rd); end
    do_req(1'b0, 3'b101, 9'h012, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h0000DEAD) begin nerr++; $display("FAIL lhu_12: got %h need 0000dead", rd); end
    do_req(1'b0, 3'b100, 9'h010, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h000000EF) begin nerr++; $display("FAIL lbu_10: got %h need 000000ef", rd); end
  endtask

  task automatic test_sb();
    int lat; logic [31:0] rd; logic flt;
    do_req(1'b1, 3'b000, 9'h011, 32'hAABBCC55, lat, rd, flt);
    nchk++; if (lat !== 1 || flt !== 1'b0) begin nerr++; $display("FAIL sb_rsp: got lat %0d fault %0b need 1/0", lat, flt); end
    do_req(1'b0, 3'b010, 9'h010, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'hDEAD55EF) begin nerr++; $display("FAIL sb_merge: got %h need dead55ef", rd); end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] rd; logic flt;
    do_req(1'b1, 3'b010, 9'h020, 32'hCAFEF00D, lat, rd, flt);
    do_req(1'b0, 3'b010, 9'h012, 32'h0, lat, rd, flt);
    nchk++; if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1) begin nerr++; $display("FAIL lw_misalign: got %0b/%h/lat %0d need 1/0/1", flt, rd, lat); end
    do_req(1'b1, 3'b001, 9'h021, 32'h0000FFFF, lat, rd, flt);
    nchk++; if (flt !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL sh_misalign: got %0b/%h need 1/0", flt, rd); end
    do_req(1'b0, 3'b011, 9'h020, 32'h0, lat, rd, flt);
    nchk++; if (flt !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL ld_f3_011: got %0b/%h need 1/0", flt, rd); end
    do_req(1'b1, 3'b011, 9'h020, 32'h11111111, lat, rd, flt);
    nchk++; if (flt !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL st_f3_011: got %0b/%h need 1/0", flt, rd); end
    do_req(1'b1, 3'b100, 9'h020, 32'h22222222, lat, rd, flt);
    nchk++; if (flt !== 1'b1) begin nerr++; $display("FAIL st_f3_100: got %0b need 1", flt); end
    do_req(1'b0, 3'b010, 9'h020, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'hCAFEF00D || flt !== 1'b0) begin nerr++; $display("FAIL fault_no_write: got %h/%0b need cafef00d/0", rd, flt); end
  endtask

  task automatic test_top_word();
    int lat; logic [31:0] rd; logic flt;
    do_req(1'b1, 3'b010, 9'h000, 32'h0BADF00D, lat, rd, flt);
    do_req(1'b1, 3'b010, 9'h1FC, 32'hA5A55A5A, lat, rd, flt);
    nchk++; if (flt !== 1'b0) begin nerr++; $display("FAIL top_sw_fault: got %0b need 0", flt); end
    do_req(1'b0, 3'b010, 9'h1FC, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'hA5A55A5A) begin nerr++; $display("FAIL top_lw: got %h need a5a55a5a", rd); end
    do_req(1'b0, 3'b010, 9'h000, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h0BADF00D) begin nerr++; $display("FAIL word0_nowrap: got %h need 0badf00d", rd); end
    do_req(1'b1, 3'b001, 9'h1FE, 32'hFFFF1234, lat, rd, flt);
    do_req(1'b0, 3'b010, 9'h1FC, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h12345A5A) begin nerr++; $display("FAIL top_sh_merge: got %h need 12345a5a", rd); end
    do_req(1'b0, 3'b000, 9'h1FD, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h0000005A) begin nerr++; $display("FAIL top_lb_pos: got %h need 0000005a", rd); end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] rd; logic flt; int hs;
    do_req(1'b1, 3'b010, 9'h030, 32'h22222222, lat, rd, flt);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h010; req_wdata = '0;
    @(posedge clk); #1;
    // keep a competing store asserted; it must not be accepted during the stall
    req_we = 1'b1; req_addr = 9'h030; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      nchk++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD55EF || rsp_fault !== 1'b0 || req_ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold[%0d]: got v%0b d%h f%0b rdy%0b need v1 dead55ef f0 rdy0",
                 i, rsp_valid, rsp_rdata, rsp_fault, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    if (rsp_valid) hs++;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (rsp_valid) hs++;
    nchk++; if (hs !== 1 || req_ready !== 1'b1) begin nerr++; $display("FAIL stall_handshake: got %0d handshakes rdy %0b need 1/1", hs, req_ready); end
    do_req(1'b0, 3'b010, 9'h030, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h22222222) begin nerr++; $display("FAIL stall_no_accept: got %h need 22222222", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic flt;
    do_req(1'b1, 3'b010, 9'h040, 32'h13579BDF, lat, rd, flt);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    nchk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin nerr++; $display("FAIL midrst_async: got v%0b rdy%0b need 0/0", rsp_valid, req_ready); end
    @(posedge clk); #1;
    nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL midrst_held: got %0b need 0", rsp_valid); end
    rst_n = 1'b1;
    #1;
    nchk++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL midrst_idle: got %0b need 1", req_ready); end
    @(posedge clk); #1;
    nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL midrst_dropped: got %0b need 0", rsp_valid); end
    do_req(1'b0, 3'b010, 9'h040, 32'h0, lat, rd, flt);
    nchk++; if (rd !== 32'h13579BDF) begin nerr++; $display("FAIL midrst_mem_kept: got %h need 13579bdf", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_ext();
    test_sb();
    test_faults();
    test_top_word();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
